// File: rtl/apb_master_bridge.sv
// APB3 requester: accepts one command at a time and runs it as a SETUP/ACCESS transfer,
// returning read data and error status on a one-cycle response strobe.
module apb_master_bridge #(
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned ADDR_WIDTH     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                  pclk_i,
  input  logic                  preset_ni,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic                  cmd_write_i,
  input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
  input  logic [DATA_WIDTH-1:0] cmd_wdata_i,
  output logic                  rsp_valid_o,
  output logic [DATA_WIDTH-1:0] rsp_rdata_o,
  output logic                  rsp_err_o,
  output logic [ADDR_WIDTH-1:0] paddr_o,
  output logic                  pwrite_o,
  output logic                  psel_o,
  output logic                  penable_o,
  output logic [DATA_WIDTH-1:0] pwdata_o,
  input  logic [DATA_WIDTH-1:0] prdata_i,
  input  logic                  pready_i,
  input  logic                  pslverr_i
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam bit          TIMEOUT_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic                  pwrite_q, pwrite_d;
  logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
  logic                  psel_q, psel_d;
  logic                  penable_q, penable_d;
  logic                  ready_q, ready_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                  rsp_err_q, rsp_err_d;

  // State and output registers; APB strobes and ready are registered decodes of next state
  always_ff @(posedge pclk_i) begin
    if (!preset_ni) begin
      state_q     <= S_IDLE;
      paddr_q     <= '0;
      pwrite_q    <= 1'b0;
      pwdata_q    <= '0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      ready_q     <= 1'b1;
      cnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      paddr_q     <= paddr_d;
      pwrite_q    <= pwrite_d;
      pwdata_q    <= pwdata_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      ready_q     <= ready_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // Next-state and transfer bookkeeping
  always_comb begin
    state_d     = state_q;
    paddr_d     = paddr_q;
    pwrite_d    = pwrite_q;
    pwdata_d    = pwdata_q;
    cnt_d       = cnt_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid_i) begin
          paddr_d  = cmd_addr_i;
          pwrite_d = cmd_write_i;
          pwdata_d = cmd_wdata_i;
          cnt_d    = '0;
          state_d  = S_SETUP;
        end
      end
      S_SETUP: begin
        state_d = S_ACCESS;
      end
      S_ACCESS: begin
        if (pready_i) begin
          state_d     = S_IDLE;
          rsp_valid_d = 1'b1;
          rsp_err_d   = pslverr_i;
          rsp_rdata_d = (!pwrite_q && !pslverr_i) ? prdata_i : '0;
        end else if (TIMEOUT_EN && (cnt_q == CNT_LAST)) begin
          // Slave stalled for the full budget: abort with error and no data
          state_d     = S_IDLE;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_rdata_d = '0;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    psel_d    = (state_d != S_IDLE);
    penable_d = (state_d == S_ACCESS);
    ready_d   = (state_d == S_IDLE);
  end

  assign cmd_ready_o = ready_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdata_o = rsp_rdata_q;
  assign rsp_err_o   = rsp_err_q;
  assign paddr_o     = paddr_q;
  assign pwrite_o    = pwrite_q;
  assign pwdata_o    = pwdata_q;
  assign psel_o      = psel_q;
  assign penable_o   = penable_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Bench for apb_master_bridge: vector table through a scoreboard, plus hand-written
// sequences for timing, wait states, timeout, back-to-back commands and mid-transfer reset.
module tb_apb_master_bridge;

  logic       clk = 1'b0;
  logic       preset_ni;
  logic       cmd_valid_i, cmd_ready_o, cmd_write_i;
  logic [7:0] cmd_addr_i, cmd_wdata_i;
  logic       rsp_valid_o, rsp_err_o;
  logic [7:0] rsp_rdata_o;
  logic [7:0] paddr_o, pwdata_o, prdata_i;
  logic       pwrite_o, psel_o, penable_o, pready_i, pslverr_i;

  always #5 clk = ~clk;

  apb_master_bridge #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .TIMEOUT_CYCLES(16)) dut (
    .pclk_i(clk), .preset_ni(preset_ni),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_write_i(cmd_write_i),
    .cmd_addr_i(cmd_addr_i), .cmd_wdata_i(cmd_wdata_i),
    .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o),
    .paddr_o(paddr_o), .pwrite_o(pwrite_o), .psel_o(psel_o), .penable_o(penable_o),
    .pwdata_o(pwdata_o), .prdata_i(prdata_i), .pready_i(pready_i), .pslverr_i(pslverr_i)
  );

  typedef struct {
    logic       wr;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] prdata;
    int         waits;
    logic       slverr;
    logic [7:0] exp_rdata;
    logic       exp_err;
  } vec_t;

  typedef struct packed {
    logic [7:0] rdata;
    logic       err;
  } rsp_t;

  rsp_t       exp_q[$];
  int         rsp_cyc[$];
  int         total = 0;
  int         bad = 0;
  int         cyc = 0;
  int         cur_wait = 0;
  logic [7:0] cur_prdata = 8'h00;
  logic       cur_slverr = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic expire(input string nm);
    total++;
    bad++;
    $display("FAIL %s: wait bound expired (cycle %0d)", nm, cyc);
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Slave model: stalls cur_wait ACCESS cycles, drives junk with pready high outside ACCESS
  initial begin
    int acc;
    acc = 0;
    pready_i = 1'b1; prdata_i = 8'hEE; pslverr_i = 1'b1;
    forever begin
      @(negedge clk);
      if (psel_o === 1'b1 && penable_o === 1'b1) begin
        if (acc < cur_wait) begin
          pready_i = 1'b0; prdata_i = 8'hEE; pslverr_i = 1'b1;
          acc++;
        end else begin
          pready_i = 1'b1; prdata_i = cur_prdata; pslverr_i = cur_slverr;
        end
      end else begin
        acc = 0;
        pready_i = 1'b1; prdata_i = 8'hEE; pslverr_i = 1'b1;
      end
    end
  end

  // Response monitor: pops the scoreboard on each response strobe
  initial forever begin
    rsp_t e;
    @(negedge clk);
    if (rsp_valid_o === 1'b1) begin
      rsp_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_rsp: got rsp_valid with rdata %0h err %0b, expected none", rsp_rdata_o, rsp_err_o);
      end else begin
        e = exp_q.pop_front();
        chk("rsp_rdata", 32'(rsp_rdata_o), 32'(e.rdata));
        chk("rsp_err", 32'(rsp_err_o), 32'(e.err));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Waits for ready at a falling edge, presents the command for one accepting edge
  task automatic issue(input vec_t v, input bit push);
    int g;
    g = 0;
    while (cmd_ready_o !== 1'b1 && g < 50) begin
      @(negedge clk);
      g++;
    end
    if (g >= 50) expire("issue_ready");
    cmd_valid_i = 1'b1;
    cmd_write_i = v.wr;
    cmd_addr_i  = v.addr;
    cmd_wdata_i = v.wdata;
    cur_wait    = v.waits;
    cur_prdata  = v.prdata;
    cur_slverr  = v.slverr;
    if (push) exp_q.push_back(rsp_t'{v.exp_rdata, v.exp_err});
    @(negedge clk);
    cmd_valid_i = 1'b0;
  endtask

  task automatic drain();
    int g;
    g = 0;
    while ((exp_q.size() != 0 || psel_o === 1'b1) && g < 100) begin
      @(negedge clk);
      g++;
    end
    if (g >= 100) expire("drain");
    @(negedge clk);
  endtask

  // Counts ACCESS cycles starting from the SETUP cycle; ends on the cycle after ACCESS
  task automatic count_access(output int n);
    n = 0;
    @(negedge clk);
    while (penable_o === 1'b1 && n < 60) begin
      n++;
      @(negedge clk);
    end
  endtask

  initial begin
    vec_t tbl[8];
    vec_t v;
    int   n;
    int   g;

    tbl[0] = '{1'b1, 8'h05, 8'h3C, 8'h00, 0,    1'b0, 8'h00, 1'b0};
    tbl[1] = '{1'b0, 8'h02, 8'h00, 8'hA5, 0,    1'b0, 8'hA5, 1'b0};
    tbl[2] = '{1'b0, 8'h10, 8'h99, 8'h11, 3,    1'b0, 8'h11, 1'b0};
    tbl[3] = '{1'b1, 8'h7F, 8'hFF, 8'h66, 2,    1'b1, 8'h00, 1'b1};
    tbl[4] = '{1'b0, 8'h33, 8'h00, 8'h5A, 0,    1'b1, 8'h00, 1'b1};
    tbl[5] = '{1'b0, 8'hFF, 8'h00, 8'hC3, 15,   1'b0, 8'hC3, 1'b0};
    tbl[6] = '{1'b0, 8'h00, 8'h00, 8'h77, 1000, 1'b0, 8'h00, 1'b1};
    tbl[7] = '{1'b1, 8'h00, 8'hA0, 8'h00, 0,    1'b0, 8'h00, 1'b0};

    preset_ni = 1'b0; cmd_valid_i = 1'b0; cmd_write_i = 1'b0;
    cmd_addr_i = 8'h00; cmd_wdata_i = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_cmd_ready", 32'(cmd_ready_o), 32'd1);
    chk("rst_psel", 32'(psel_o), 32'd0);
    chk("rst_penable", 32'(penable_o), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
    chk("rst_rsp_rdata", 32'(rsp_rdata_o), 32'd0);
    chk("rst_rsp_err", 32'(rsp_err_o), 32'd0);
    chk("rst_paddr", 32'(paddr_o), 32'd0);
    chk("rst_pwrite", 32'(pwrite_o), 32'd0);
    chk("rst_pwdata", 32'(pwdata_o), 32'd0);
    preset_ni = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      issue(tbl[i], 1'b1);
      drain();
    end

    // Zero-wait write: SETUP, ACCESS, then response in the following IDLE cycle
    issue(tbl[0], 1'b1);
    chk("wr_setup_psel", 32'(psel_o), 32'd1);
    chk("wr_setup_penable", 32'(penable_o), 32'd0);
    chk("wr_setup_paddr", 32'(paddr_o), 32'h05);
    chk("wr_setup_pwdata", 32'(pwdata_o), 32'h3C);
    chk("wr_setup_pwrite", 32'(pwrite_o), 32'd1);
    chk("wr_setup_ready", 32'(cmd_ready_o), 32'd0);
    @(negedge clk);
    chk("wr_access_psel", 32'(psel_o), 32'd1);
    chk("wr_access_penable", 32'(penable_o), 32'd1);
    chk("wr_access_ready", 32'(cmd_ready_o), 32'd0);
    @(negedge clk);
    chk("wr_rsp_valid", 32'(rsp_valid_o), 32'd1);
    chk("wr_idle_psel", 32'(psel_o), 32'd0);
    chk("wr_idle_ready", 32'(cmd_ready_o), 32'd1);
    chk("wr_idle_paddr_hold", 32'(paddr_o), 32'h05);
    @(negedge clk);
    chk("wr_rsp_single_pulse", 32'(rsp_valid_o), 32'd0);

    // Zero-wait read with address stability and response data hold
    issue(tbl[1], 1'b1);
    chk("rd_setup_paddr", 32'(paddr_o), 32'h02);
    chk("rd_setup_pwrite", 32'(pwrite_o), 32'd0);
    @(negedge clk);
    chk("rd_access_paddr", 32'(paddr_o), 32'h02);
    @(negedge clk);
    chk("rd_rsp_valid", 32'(rsp_valid_o), 32'd1);
    @(negedge clk);
    chk("rd_rsp_rdata_hold", 32'(rsp_rdata_o), 32'hA5);
    chk("rd_rsp_valid_low", 32'(rsp_valid_o), 32'd0);

    // Three wait states: four ACCESS cycles
    issue(tbl[2], 1'b1);
    count_access(n);
    chk("wait3_access_cycles", 32'(n), 32'd4);
    chk("wait3_rsp_valid", 32'(rsp_valid_o), 32'd1);
    chk("wait3_rsp_err", 32'(rsp_err_o), 32'd0);
    drain();

    // Permanent stall: abort after exactly 16 ACCESS cycles
    issue(tbl[6], 1'b1);
    count_access(n);
    chk("tmo_access_cycles", 32'(n), 32'd16);
    chk("tmo_psel_after", 32'(psel_o), 32'd0);
    chk("tmo_rsp_valid", 32'(rsp_valid_o), 32'd1);
    chk("tmo_rsp_err", 32'(rsp_err_o), 32'd1);
    chk("tmo_rsp_rdata", 32'(rsp_rdata_o), 32'd0);
    drain();

    // Reset during ACCESS: bus released, no response, response registers cleared
    v = tbl[6];
    issue(v, 1'b0);
    @(negedge clk);
    chk("rstmid_in_access", 32'(penable_o), 32'd1);
    @(negedge clk);
    preset_ni = 1'b0;
    @(negedge clk);
    chk("rstmid_psel", 32'(psel_o), 32'd0);
    chk("rstmid_penable", 32'(penable_o), 32'd0);
    chk("rstmid_ready", 32'(cmd_ready_o), 32'd1);
    chk("rstmid_rsp_valid", 32'(rsp_valid_o), 32'd0);
    chk("rstmid_rsp_err", 32'(rsp_err_o), 32'd0);
    preset_ni = 1'b1;
    @(negedge clk);
    chk("rstmid_no_rsp", 32'(rsp_valid_o), 32'd0);
    @(negedge clk);
    issue(tbl[1], 1'b1);
    drain();

    // Back-to-back writes with cmd_valid held high
    rsp_cyc.delete();
    cur_wait = 0; cur_slverr = 1'b0;
    cmd_valid_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      g = 0;
      while (cmd_ready_o !== 1'b1 && g < 20) begin
        @(negedge clk);
        g++;
      end
      if (i > 0) chk("b2b_busy_cycles", 32'(g), 32'd2);
      cmd_write_i = 1'b1;
      cmd_addr_i  = 8'(8'h40 + i);
      cmd_wdata_i = 8'(8'h90 + i);
      exp_q.push_back(rsp_t'{8'h00, 1'b0});
      @(negedge clk);
      chk("b2b_paddr", 32'(paddr_o), 32'(8'h40 + i));
      chk("b2b_pwdata", 32'(pwdata_o), 32'(8'h90 + i));
    end
    cmd_valid_i = 1'b0;
    drain();
    chk("b2b_rsp_count", 32'(rsp_cyc.size()), 32'd3);
    if (rsp_cyc.size() == 3) begin
      chk("b2b_spacing_1", 32'(rsp_cyc[1] - rsp_cyc[0]), 32'd3);
      chk("b2b_spacing_2", 32'(rsp_cyc[2] - rsp_cyc[1]), 32'd3);
    end

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
